// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states,
// and the iteration count of the multi-cycle algorithms.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  localparam int MD_ITERATIONS = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding HI and LO.
// MULT/MULTU: 32 shift-add steps on a 64-bit {upper, multiplier} register.
// DIV/DIVU: 32 restoring steps on a 64-bit {remainder, dividend/quotient} register.
// Signed ops run on magnitudes; signs are fixed up on the completing edge, so
// HI/LO only ever change at that edge (or at an MTHI/MTLO issue edge).
// Issue handshake: start is a one-cycle strobe accepted only at a rising edge
// where busy is 0 and op is valid; anything else is dropped without effect.
// dbg_state exposes the FSM state for checkers.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam logic [4:0] LAST_STEP = 5'(MD_ITERATIONS - 1);

  md_state_t          state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   raw_rs_q, raw_rs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               divz_q, divz_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   mag_rs, mag_rt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fin;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fin, rem_fin;
  logic               is_signed;

  // One arithmetic step of each algorithm plus the final sign fix-ups.
  always_comb begin
    mag_rs    = rs[WIDTH-1] ? -rs : rs;
    mag_rt    = rt[WIDTH-1] ? -rt : rt;
    // Shift-add: add multiplicand to the upper half when the current
    // multiplier bit (LSB) is set, then shift the whole 65-bit value right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[2*WIDTH-1:1]};
    prod_fin  = neg_lo_q ? -mul_next : mul_next;
    // Restoring divide: 33-bit partial remainder is {rem, next dividend bit}.
    // The remainder is always below the divisor, so the difference fits W bits.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    quo_fin   = neg_lo_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem_fin   = neg_hi_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  // FSM next-state: issue decode in IDLE, iterate and commit in MUL/DIV.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    raw_rs_d  = raw_rs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    divz_d    = divz_q;
    busy_d    = busy_q;
    is_signed = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              is_signed = (op == MD_MULT);
              opb_d     = is_signed ? mag_rs : rs;
              acc_d     = {{WIDTH{1'b0}}, (is_signed ? mag_rt : rt)};
              neg_lo_d  = is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
              neg_hi_d  = neg_lo_d;
              divz_d    = 1'b0;
              cnt_d     = 5'd0;
              busy_d    = 1'b1;
              state_d   = ST_MUL;
            end
            MD_DIV, MD_DIVU: begin
              is_signed = (op == MD_DIV);
              opb_d     = is_signed ? mag_rt : rt;
              acc_d     = {{WIDTH{1'b0}}, (is_signed ? mag_rs : rs)};
              neg_lo_d  = is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
              neg_hi_d  = is_signed & rs[WIDTH-1];
              divz_d    = (rt == '0);
              raw_rs_d  = rs;
              cnt_d     = 5'd0;
              busy_d    = 1'b1;
              state_d   = ST_DIV;
            end
            MD_MTHI: hi_d = rs;
            MD_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          hi_d    = prod_fin[2*WIDTH-1:WIDTH];
          lo_d    = prod_fin[WIDTH-1:0];
          cnt_d   = 5'd0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          // Divide by zero returns all-ones quotient and the untouched dividend.
          lo_d    = divz_q ? {WIDTH{1'b1}} : quo_fin;
          hi_d    = divz_q ? raw_rs_q : rem_fin;
          cnt_d   = 5'd0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= '0;
      opb_q    <= '0;
      raw_rs_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      divz_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      raw_rs_q <= raw_rs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      divz_q   <= divz_d;
      busy_q   <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: reset, MTHI/MTLO, multiply and divide
// values, divide edge cases, start-while-busy and reset-while-busy.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;
  int cycles;
  int extra;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock: rising edges at 5, 15, 25, ...; inputs driven and outputs sampled on falling edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one start strobe for exactly one rising edge; returns just after that edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    rs    = $urandom;
    rt    = $urandom;
  endtask

  // Count falling edges with busy high (bounded), checking HI/LO hold their old values.
  task automatic wait_done(input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                           output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      check("hold_hi", hi, hold_hi);
      check("hold_lo", lo, hold_lo);
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 3'd0;
    rs       = 32'h0;
    rt       = 32'h0;

    // Asynchronous reset values visible before any clock edge.
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;

    // MTLO: single-cycle write, no busy.
    issue(3'(MD_MTLO), 32'hDEADBEEF, 32'h0);
    check("mtlo_lo", lo, 32'hDEADBEEF);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("mtlo_busy2", {31'b0, busy}, 32'd0);

    // MULTU max x max.
    issue(3'(MD_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_state", {30'b0, dbg_state}, 32'(ST_MUL));
    wait_done(32'h0, 32'hDEADBEEF, cycles);
    check("multu_cycles", 32'(cycles), 32'd32);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    // MTHI preload, then MULT -3 x 5 with HI held through busy.
    issue(3'(MD_MTHI), 32'h11111111, 32'h0);
    check("mthi_hi", hi, 32'h11111111);
    issue(3'(MD_MULT), 32'hFFFFFFFD, 32'd5);
    wait_done(32'h11111111, 32'h00000001, cycles);
    check("mult_cycles", 32'(cycles), 32'd32);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);

    // DIV -7 / 2.
    issue(3'(MD_DIV), 32'hFFFFFFF9, 32'd2);
    check("div_state", {30'b0, dbg_state}, 32'(ST_DIV));
    wait_done(32'hFFFFFFFF, 32'hFFFFFFF1, cycles);
    check("div_cycles", 32'(cycles), 32'd32);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    // DIVU 100 / 7.
    issue(3'(MD_DIVU), 32'd100, 32'd7);
    wait_done(32'hFFFFFFFF, 32'hFFFFFFFD, cycles);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // DIV by zero.
    issue(3'(MD_DIV), 32'h00001234, 32'h0);
    wait_done(32'd2, 32'd14, cycles);
    check("divz_cycles", 32'(cycles), 32'd32);
    check("divz_lo", lo, 32'hFFFFFFFF);
    check("divz_hi", hi, 32'h00001234);

    // DIV overflow.
    issue(3'(MD_DIV), 32'h80000000, 32'hFFFFFFFF);
    wait_done(32'h00001234, 32'hFFFFFFFF, cycles);
    check("divov_lo", lo, 32'h80000000);
    check("divov_hi", hi, 32'h0);

    // MULTU 6 x 7 with a second MULTU strobe at busy cycle 5 (must be dropped).
    issue(3'(MD_MULTU), 32'd6, 32'd7);
    cycles = 0;
    repeat (4) begin
      cycles++;
      @(negedge clk);
    end
    start = 1'b1;
    op    = 3'(MD_MULTU);
    rs    = 32'd100;
    rt    = 32'd100;
    cycles++;
    @(negedge clk);
    start = 1'b0;
    wait_done(32'h0, 32'h80000000, extra);
    check("ign_cycles", 32'(cycles + extra), 32'd32);
    check("ign_hi", hi, 32'h0);
    check("ign_lo", lo, 32'd42);
    @(negedge clk);
    check("ign_busy_after", {31'b0, busy}, 32'd0);
    check("ign_lo_after", lo, 32'd42);

    // Invalid op is ignored.
    issue(3'd6, 32'h55555555, 32'h3);
    check("inv_busy", {31'b0, busy}, 32'd0);
    check("inv_hi", hi, 32'h0);
    check("inv_lo", lo, 32'd42);

    // Reset mid-clock at busy cycle 10 of a DIVU.
    issue(3'(MD_DIVU), 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_after_busy", {31'b0, busy}, 32'd0);
    check("rst_after_hi", hi, 32'h0);
    check("rst_after_lo", lo, 32'h0);
    check("rst_after_state", {30'b0, dbg_state}, 32'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
